// File: rtl/mem_dbus_ctrl.sv
// M-stage data bus controller: one addr_ok/data_ok bus transaction per M
// instruction, pipeline stall until data returns, flush-safe draining.
//
// Ports:
//   clk, rst                    clock, async active-low reset
//   m_data_req/wr/size/addr/wdata   level request from the M stage
//   m_exc_flush, m_advance      M-stage kill and advance strobes
//   data_req/wr/size/addr/wdata bus request channel
//   data_addr_ok, data_data_ok  bus handshakes
//   data_rdata                  bus read data
//   m_rdata, m_dstall           read data and stall back to M
//   perf_dstall                 stall-cycle counter
module mem_dbus_ctrl #(
   parameter int DATA_W = 32,
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m_data_req,
   input  logic              m_data_wr,
   input  logic [1:0]        m_data_size,
   input  logic [DATA_W-1:0] m_data_addr,
   input  logic [DATA_W-1:0] m_data_wdata,
   input  logic              m_exc_flush,
   input  logic              m_advance,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [DATA_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata,
   output logic [DATA_W-1:0] m_rdata,
   output logic              m_dstall,
   output logic [PERF_W-1:0] perf_dstall
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              cancel_q, cancel_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [PERF_W-1:0] perf_q, perf_d;

   logic issue;
   logic st_idle, st_req, st_wait;

   assign issue   = m_data_req & ~m_exc_flush;
   assign st_idle = (state_q == S_IDLE);
   assign st_req  = (state_q == S_REQ);
   assign st_wait = (state_q == S_WAIT);

   // IDLE forwards the M request with no added latency; afterwards the
   // latched copy keeps the bus fields stable until addr_ok.
   always_comb begin
      if (st_idle) begin
         data_req   = issue;
         data_wr    = m_data_wr;
         data_size  = m_data_size;
         data_addr  = m_data_addr;
         data_wdata = m_data_wdata;
      end else begin
         data_req   = st_req;
         data_wr    = wr_q;
         data_size  = size_q;
         data_addr  = addr_q;
         data_wdata = wdata_q;
      end
   end

   assign m_rdata = (st_wait && data_data_ok) ? data_rdata : rdata_q;

   // A cancelled transaction keeps M stalled until it has fully drained.
   assign m_dstall = (st_idle & issue)
                   | st_req
                   | (st_wait & ~(data_data_ok & ~cancel_q))
                   | (st_wait & cancel_q);

   assign perf_dstall = perf_q;
   assign perf_d      = perf_q + {{(PERF_W-1){1'b0}}, m_dstall};

   always_comb begin
      state_d  = state_q;
      cancel_d = cancel_q;
      wr_d     = wr_q;
      size_d   = size_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (issue) begin
               wr_d    = m_data_wr;
               size_d  = m_data_size;
               addr_d  = m_data_addr;
               wdata_d = m_data_wdata;
               state_d = data_addr_ok ? S_WAIT : S_REQ;
            end
         end
         S_REQ: begin
            if (m_exc_flush) cancel_d = 1'b1;
            if (data_addr_ok) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (m_exc_flush) cancel_d = 1'b1;
            // data_ok is only looked at here, so a data_ok coinciding
            // with addr_ok in IDLE/REQ is ignored.
            if (data_data_ok) begin
               rdata_d  = data_rdata;
               cancel_d = 1'b0;
               if (cancel_q || m_exc_flush || m_advance)
                  state_d = S_IDLE;
               else
                  state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Result held; no re-issue even though m_data_req stays high.
            if (m_advance) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cancel_q <= 1'b0;
         wr_q     <= 1'b0;
         size_q   <= 2'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         perf_q   <= '0;
      end else begin
         state_q  <= state_d;
         cancel_q <= cancel_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         perf_q   <= perf_d;
      end
   end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Testbench for mem_dbus_ctrl: scripted bus slave, scoreboard of
// expected bus transactions, inline checks of stall and read data.
module tb_mem_dbus_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        m_data_req, m_data_wr, m_exc_flush, m_advance;
   logic [1:0]  m_data_size;
   logic [31:0] m_data_addr, m_data_wdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata, m_rdata;
   logic        m_dstall;
   logic [31:0] perf_dstall;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   bus_t exp_q[$];

   mem_dbus_ctrl #(.DATA_W(32), .PERF_W(32)) dut (
      .clk(clk), .rst(rst),
      .m_data_req(m_data_req), .m_data_wr(m_data_wr),
      .m_data_size(m_data_size), .m_data_addr(m_data_addr),
      .m_data_wdata(m_data_wdata), .m_exc_flush(m_exc_flush),
      .m_advance(m_advance),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .m_rdata(m_rdata), .m_dstall(m_dstall), .perf_dstall(perf_dstall)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: timeout, got no finish, wanted finish");
      $fatal(1, "timeout");
   end

   // Bus monitor: every accepted request must match the next expected one.
   always @(negedge clk) begin
      if (rst && data_req && data_addr_ok) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL bus_dup: got addr %h, wanted no request",
                     data_addr);
         end else begin
            bus_t e;
            e = exp_q.pop_front();
            if (data_wr !== e.wr || data_size !== e.size ||
                data_addr !== e.addr || (e.wr && data_wdata !== e.wdata)) begin
               n_err++;
               $display("FAIL bus_txn: got wr=%b sz=%0d a=%h d=%h, wanted wr=%b sz=%0d a=%h d=%h",
                        data_wr, data_size, data_addr, data_wdata,
                        e.wr, e.size, e.addr, e.wdata);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      m_data_req   = 1'b0;
      m_data_wr    = 1'b0;
      m_data_size  = 2'd0;
      m_data_addr  = 32'h0;
      m_data_wdata = 32'h0;
      m_exc_flush  = 1'b0;
      m_advance    = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = 32'h0;
   endtask

   task automatic drive_req(input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d);
      bus_t e;
      m_data_req   = 1'b1;
      m_data_wr    = wr;
      m_data_size  = sz;
      m_data_addr  = a;
      m_data_wdata = d;
      e.wr = wr; e.size = sz; e.addr = a; e.wdata = d;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      idle_in();
      rst = 1'b0;
      #1;
      n_vec++;
      if (data_req !== 1'b0 || m_dstall !== 1'b0 ||
          m_rdata !== 32'h0 || perf_dstall !== 32'h0) begin
         n_err++;
         $display("FAIL reset: got req=%b stall=%b rdata=%h perf=%0d, wanted 0 0 0 0",
                  data_req, m_dstall, m_rdata, perf_dstall);
      end
      tick(); tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_load_word();
      drive_req(1'b0, 2'd2, 32'h8000_0010, 32'h0);
      data_addr_ok = 1'b1;
      #1;
      n_vec++;
      if (data_req !== 1'b1 || m_dstall !== 1'b1 || data_addr !== 32'h8000_0010) begin
         n_err++;
         $display("FAIL ld_c0: got req=%b stall=%b a=%h, wanted 1 1 80000010",
                  data_req, m_dstall, data_addr);
      end
      tick();
      data_addr_ok = 1'b0;
      #1;
      n_vec++;
      if (data_req !== 1'b0 || m_dstall !== 1'b1) begin
         n_err++;
         $display("FAIL ld_c1: got req=%b stall=%b, wanted 0 1", data_req, m_dstall);
      end
      tick();
      data_data_ok = 1'b1;
      data_rdata   = 32'hDEAD_BEEF;
      m_advance    = 1'b1;
      #1;
      n_vec++;
      if (m_dstall !== 1'b0 || m_rdata !== 32'hDEAD_BEEF || data_req !== 1'b0) begin
         n_err++;
         $display("FAIL ld_c2: got stall=%b rdata=%h req=%b, wanted 0 deadbeef 0",
                  m_dstall, m_rdata, data_req);
      end
      tick();
      idle_in();
      #1;
      n_vec++;
      if (perf_dstall !== 32'd2) begin
         n_err++;
         $display("FAIL ld_perf: got %0d, wanted 2", perf_dstall);
      end
      tick();
   endtask

   task automatic test_store_delayed();
      drive_req(1'b1, 2'd0, 32'h0000_0003, 32'h0000_00AB);
      #1;
      n_vec++;
      if (data_req !== 1'b1 || m_dstall !== 1'b1) begin
         n_err++;
         $display("FAIL st_c0: got req=%b stall=%b, wanted 1 1", data_req, m_dstall);
      end
      for (int c = 1; c <= 3; c++) begin
         tick();
         // Perturb the M-side fields; the bus must show the latched copy.
         m_data_addr  = 32'hFFFF_0000 + c;
         m_data_wdata = 32'h1111_1111 * c;
         m_data_size  = 2'd2;
         data_addr_ok = (c == 3);
         #1;
         n_vec++;
         if (data_req !== 1'b1 || data_wr !== 1'b1 || data_size !== 2'd0 ||
             data_addr !== 32'h3 || data_wdata !== 32'hAB || m_dstall !== 1'b1) begin
            n_err++;
            $display("FAIL st_req%0d: got req=%b wr=%b sz=%0d a=%h d=%h stall=%b, wanted 1 1 0 3 ab 1",
                     c, data_req, data_wr, data_size, data_addr, data_wdata, m_dstall);
         end
      end
      tick();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b1;
      m_advance    = 1'b1;
      #1;
      n_vec++;
      if (m_dstall !== 1'b0 || data_req !== 1'b0) begin
         n_err++;
         $display("FAIL st_done: got stall=%b req=%b, wanted 0 0", m_dstall, data_req);
      end
      tick();
      idle_in();
      tick();
   endtask

   task automatic test_hold();
      drive_req(1'b0, 2'd2, 32'h0000_0100, 32'h0);
      data_addr_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b1;
      data_rdata   = 32'h1234_5678;
      #1;
      n_vec++;
      if (m_dstall !== 1'b0 || m_rdata !== 32'h1234_5678) begin
         n_err++;
         $display("FAIL hold_dok: got stall=%b rdata=%h, wanted 0 12345678",
                  m_dstall, m_rdata);
      end
      tick();
      // addr_ok held high so any spurious re-issue is seen by the monitor.
      data_data_ok = 1'b0;
      data_addr_ok = 1'b1;
      for (int c = 0; c < 4; c++) begin
         data_rdata = 32'hBAD0_0000 + c;
         #1;
         n_vec++;
         if (m_rdata !== 32'h1234_5678 || data_req !== 1'b0 || m_dstall !== 1'b0) begin
            n_err++;
            $display("FAIL hold%0d: got rdata=%h req=%b stall=%b, wanted 12345678 0 0",
                     c, m_rdata, data_req, m_dstall);
         end
         tick();
      end
      data_addr_ok = 1'b0;
      m_advance    = 1'b1;
      tick();
      idle_in();
      tick();
   endtask

   task automatic test_flush();
      drive_req(1'b0, 2'd2, 32'h0000_0200, 32'h0);
      data_addr_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0;
      m_exc_flush  = 1'b1;
      #1;
      n_vec++;
      if (m_dstall !== 1'b1) begin
         n_err++;
         $display("FAIL fl_wait: got stall=%b, wanted 1", m_dstall);
      end
      tick();
      m_exc_flush = 1'b0;
      m_data_req  = 1'b0;
      #1;
      n_vec++;
      if (m_dstall !== 1'b1 || data_req !== 1'b0) begin
         n_err++;
         $display("FAIL fl_hold: got stall=%b req=%b, wanted 1 0", m_dstall, data_req);
      end
      tick();
      data_data_ok = 1'b1;
      data_rdata   = 32'h0000_0055;
      #1;
      n_vec++;
      if (m_dstall !== 1'b1) begin
         n_err++;
         $display("FAIL fl_drain: got stall=%b, wanted 1", m_dstall);
      end
      tick();
      data_data_ok = 1'b0;
      #1;
      n_vec++;
      if (m_dstall !== 1'b0 || data_req !== 1'b0) begin
         n_err++;
         $display("FAIL fl_idle: got stall=%b req=%b, wanted 0 0", m_dstall, data_req);
      end
      drive_req(1'b0, 2'd2, 32'h0000_0204, 32'h0);
      data_addr_ok = 1'b1;
      #1;
      n_vec++;
      if (data_req !== 1'b1 || m_dstall !== 1'b1) begin
         n_err++;
         $display("FAIL fl_next: got req=%b stall=%b, wanted 1 1", data_req, m_dstall);
      end
      tick();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b1;
      data_rdata   = 32'hCAFE_F00D;
      m_advance    = 1'b1;
      #1;
      n_vec++;
      if (m_rdata !== 32'hCAFE_F00D || m_dstall !== 1'b0) begin
         n_err++;
         $display("FAIL fl_next_d: got rdata=%h stall=%b, wanted cafef00d 0",
                  m_rdata, m_dstall);
      end
      tick();
      idle_in();
      m_data_req  = 1'b1;
      m_data_addr = 32'h0000_0300;
      m_exc_flush = 1'b1;
      data_addr_ok = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_vec++;
         if (data_req !== 1'b0 || m_dstall !== 1'b0) begin
            n_err++;
            $display("FAIL fl_idle_sup%0d: got req=%b stall=%b, wanted 0 0",
                     c, data_req, m_dstall);
         end
         tick();
      end
      idle_in();
      tick();
   endtask

   task automatic test_reset_mid();
      drive_req(1'b0, 2'd2, 32'h0000_0400, 32'h0);
      data_addr_ok = 1'b1;
      tick();
      idle_in();
      #2;
      rst = 1'b0;
      #1;
      n_vec++;
      if (data_req !== 1'b0 || m_dstall !== 1'b0 ||
          perf_dstall !== 32'h0 || m_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL rst_mid: got req=%b stall=%b perf=%0d rdata=%h, wanted 0 0 0 0",
                  data_req, m_dstall, perf_dstall, m_rdata);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
      #1;
      n_vec++;
      if (m_dstall !== 1'b0 || perf_dstall !== 32'h0) begin
         n_err++;
         $display("FAIL rst_after: got stall=%b perf=%0d, wanted 0 0",
                  m_dstall, perf_dstall);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] p0;
      p0 = perf_dstall;
      for (int k = 0; k < 4; k++) begin
         drive_req(1'b0, 2'd2, 32'h0000_1000 + 32'(k * 4), 32'h0);
         data_addr_ok = 1'b1;
         data_data_ok = 1'b0;
         m_advance    = 1'b0;
         #1;
         n_vec++;
         if (data_req !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_req%0d: got %b, wanted 1", k, data_req);
         end
         tick();
         data_addr_ok = 1'b0;
         data_data_ok = 1'b1;
         data_rdata   = 32'hA500_0000 + 32'(k);
         m_advance    = 1'b1;
         #1;
         n_vec++;
         if (m_rdata !== 32'hA500_0000 + 32'(k) || m_dstall !== 1'b0 ||
             data_req !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_dat%0d: got rdata=%h stall=%b req=%b, wanted %h 0 0",
                     k, m_rdata, m_dstall, data_req, 32'hA500_0000 + 32'(k));
         end
         tick();
      end
      idle_in();
      #1;
      n_vec++;
      if (perf_dstall !== p0 + 32'd4) begin
         n_err++;
         $display("FAIL b2b_perf: got %0d, wanted %0d", perf_dstall, p0 + 32'd4);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_store_delayed();
      test_hold();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      tick();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL bus_missing: got %0d unissued, wanted 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
